div_ctrl: RTL and testbench

Iterative radix-2 divider controller for the EX stage of the five-stage RV32 pipeline. It accepts RV32M DIV/DIVU/REM/REMU operations, sequences a 1-bit-per-cycle restoring division, and produces the `ex_stall` that freezes the whole pipeline in the hazard unit until the result is ready. The instruction stays in EX for the entire operation; the result is muxed into the EX result path in the single cycle `ex_stall` drops.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/div_step.sv | 32 +++
 rtl/div_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the EX-stage divider controller.
// The divider fast special-case path is enabled by DIV_FAST_SPECIAL_EN (see div_ctrl).
package riscv_pkg;

  localparam int XLEN          = 32;
  localparam int DIV_CNT_WIDTH = $clog2(XLEN);

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem, quo[W-1]};
  // rem < divisor keeps the true difference inside W+1 signed bits, so bit W is the sign
  assign diff    = shifted - {1'b0, divisor};

  // Restore or keep the trial difference
  always_comb begin
    rem_next = shifted[W-1:0];
    quo_next = {quo[W-2:0], 1'b0};
    if (diff[W] == 1'b0) begin
      rem_next = diff[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative radix-2 RV32M divider controller with pipeline stall generation.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete in the accept cycle.
module div_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state;
  div_state_e      state_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] fin_value;
  logic [XLEN-1:0] fast_value;
  logic [XLEN-1:0] result_reg;
  logic            neg_q;
  logic            neg_r;
  logic            want_rem;
  logic            op_signed;
  logic            accept;
  logic            fast;

  assign op_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);

`ifdef DIV_FAST_SPECIAL_EN
  logic div_zero;
  logic overflow;

  assign div_zero = (rs2_data == {XLEN{1'b0}});
  assign overflow = op_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_data == {XLEN{1'b1}});
  assign fast     = (state == DIV_IDLE) && start && !kill && (div_zero || overflow);

  // Architectural results of the two special cases
  always_comb begin
    fast_value = {XLEN{1'b0}};
    if (div_zero) begin
      fast_value = op[1] ? rs1_data : {XLEN{1'b1}};
    end else begin
      fast_value = op[1] ? {XLEN{1'b0}} : rs1_data;
    end
  end
`else
  assign fast       = 1'b0;
  assign fast_value = {XLEN{1'b0}};
`endif

  assign accept       = (state == DIV_IDLE) && start && !kill && !fast;
  assign ex_stall     = accept || (state == DIV_BUSY);
  assign busy         = (state != DIV_IDLE);
  assign result_valid = (state == DIV_DONE) || fast;
  assign result       = fast ? fast_value : result_reg;

  div_step #(.W(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Sign fixup on the final iteration's output, captured as DONE is entered
  always_comb begin
    fin_value = {XLEN{1'b0}};
    if (want_rem) begin
      fin_value = neg_r ? -rem_step : rem_step;
    end else begin
      fin_value = neg_q ? -quo_step : quo_step;
    end
  end

  // Next-state logic; kill always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: begin
        if (accept) state_next = DIV_BUSY;
        else        state_next = DIV_IDLE;
      end
      DIV_BUSY: begin
        if (kill)                     state_next = DIV_IDLE;
        else if (count == {CW{1'b0}}) state_next = DIV_DONE;
        else                          state_next = DIV_BUSY;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // State, operand latch, iteration registers and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIV_IDLE;
      count      <= {CW{1'b0}};
      rem        <= {XLEN{1'b0}};
      quo        <= {XLEN{1'b0}};
      divisor    <= {XLEN{1'b0}};
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      want_rem   <= 1'b0;
      result_reg <= {XLEN{1'b0}};
    end else begin
      state <= state_next;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            rem      <= {XLEN{1'b0}};
            quo      <= (op_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
            divisor  <= (op_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
            neg_q    <= op_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1])
                        && (rs2_data != {XLEN{1'b0}});
            neg_r    <= op_signed && rs1_data[XLEN-1];
            want_rem <= op[1];
            count    <= CW'(XLEN - 1);
          end else if (fast) begin
            result_reg <= fast_value;
          end
        end
        DIV_BUSY: begin
          if (!kill) begin
            rem <= rem_step;
            quo <= quo_step;
            if (count == {CW{1'b0}}) result_reg <= fin_value;
            else                     count      <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed RV32M cases plus randomized ops vs a reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_stall;
  logic        result_valid;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kill         (kill),
    .op           (op),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .ex_stall     (ex_stall),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_signed_op(input logic [1:0] o);
    return (o == 2'd0) || (o == 2'd2);
  endfunction

  function automatic logic special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RV32M semantics from plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (is_signed_op(o)) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    int          cyc;
    int          exp_stalls;
    logic [31:0] exp;
    stalls     = 0;
    cyc        = 0;
    exp        = model(o, a, b);
    exp_stalls = 33;
`ifdef DIV_FAST_SPECIAL_EN
    if (special(o, a, b)) exp_stalls = 0;
`endif
    op       = o;
    rs1_data = a;
    rs2_data = b;
    start    = 1'b1;
    #1;
    while (result_valid !== 1'b1 && cyc < 40) begin
      if (ex_stall === 1'b1) stalls++;
      @(posedge clk);
      #2;
      cyc++;
    end
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, "_stall_at_done"}, 32'(ex_stall), 32'd0);
    chk({tag, "_result"}, result, exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_result_hold"}, result, exp);
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op       = o;
    rs1_data = a;
    rs2_data = b;
    start    = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    #1;
    chk("rst_ex_stall", 32'(ex_stall), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    do_op("divu_100_7", 2'd1, 32'd100, 32'd7);
    chk("divu_100_7_const", result, 32'd14);
    do_op("remu_100_7", 2'd3, 32'd100, 32'd7);
    chk("remu_100_7_const", result, 32'd2);
    do_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_const", result, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("rem_m7_2_const", result, 32'hFFFF_FFFF);
    do_op("div_by_zero", 2'd0, 32'hFFFF_FFFB, 32'd0);
    do_op("rem_by_zero", 2'd2, 32'hFFFF_FFFB, 32'd0);
    do_op("divu_by_zero", 2'd1, 32'd1234, 32'd0);
    do_op("div_overflow", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // kill in IDLE beats start
    op = 2'd1; rs1_data = 32'd50; rs2_data = 32'd5; start = 1'b1; kill = 1'b1;
    #1;
    chk("kill_idle_stall", 32'(ex_stall), 32'd0);
    @(posedge clk);
    #2;
    chk("kill_idle_busy", 32'(busy), 32'd0);
    kill = 1'b0; start = 1'b0;
    #1;

    // abort at BUSY cycle 10
    launch(2'd1, 32'd12345, 32'd17);
    repeat (9) @(posedge clk);
    #2;
    chk("abort_busy_before", 32'(busy), 32'd1);
    kill = 1'b1; start = 1'b0;
    @(posedge clk);
    #2;
    kill = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stall", 32'(ex_stall), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    do_op("after_abort_divu_9_3", 2'd1, 32'd9, 32'd3);

    // kill on the last BUSY cycle must not reach DONE
    launch(2'd0, 32'd1000, 32'd3);
    repeat (31) @(posedge clk);
    #2;
    chk("lastkill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1; start = 1'b0;
    @(posedge clk);
    #2;
    kill = 1'b0;
    #1;
    chk("lastkill_busy", 32'(busy), 32'd0);
    chk("lastkill_valid", 32'(result_valid), 32'd0);
    @(posedge clk);
    #2;
    chk("lastkill_valid_next", 32'(result_valid), 32'd0);

    // reset at BUSY cycle 5
    launch(2'd1, 32'd777, 32'd5);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("midrst_ex_stall", 32'(ex_stall), 32'd0);
    chk("midrst_result_valid", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    do_op("b2b_divu_10_2", 2'd1, 32'd10, 32'd2);
    do_op("b2b_divu_9_3", 2'd1, 32'd9, 32'd3);

    for (int i = 0; i < 24; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel == 3) rb = ~32'($urandom_range(0, 7));
      do_op("rnd", ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
